// File: rtl/fs_strobe_monitor_if.sv
// Observation bus for fs_strobe_monitor: per-channel valid, DUT data, golden data and X-mask.
// The test wrapper drives the master side and the monitor samples the slave side.
interface fs_strobe_monitor_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 32
);
  logic [NUM_CH-1:0]        obs_valid_i;
  logic [NUM_CH*DATA_W-1:0] obs_data_i;
  logic [NUM_CH*DATA_W-1:0] gold_data_i;
  logic [NUM_CH*DATA_W-1:0] obs_xmask_i;

  modport master (
    output obs_valid_i,
    output obs_data_i,
    output gold_data_i,
    output obs_xmask_i
  );

  modport slave (
    input obs_valid_i,
    input obs_data_i,
    input gold_data_i,
    input obs_xmask_i
  );
endinterface

// File: rtl/fs_strobe_monitor.sv
// Fault-simulation strobe monitor: waits a programmable delay after start, pulses inject,
// then compares NUM_CH observed channels against golden values every STROBE_PERIOD cycles,
// tracking sticky definite (detect) and potential (X-masked) mismatches per channel.
// Optional per-channel MISR signatures are built when FS_STROBE_MISR_EN is defined;
// otherwise sig_o is tied to zero.
module fs_strobe_monitor #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned INJ_DELAY     = 8,
  parameter int unsigned STROBE_PERIOD = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     stop_i,
  fs_strobe_monitor_if.slave       obs,
  output logic                     inject_o,
  output logic [NUM_CH-1:0]        detect_o,
  output logic [NUM_CH-1:0]        potential_o,
  output logic                     all_detected_o,
  output logic                     done_o,
  output logic [15:0]              mism_cnt_o,
  output logic [NUM_CH*DATA_W-1:0] sig_o
);

  typedef enum logic [2:0] {StIdle, StWaitInj, StInject, StStrobe, StDone} state_e;

  state_e            state_q, state_d;
  logic [7:0]        dly_q, dly_d;
  logic [7:0]        per_q, per_d;
  logic [NUM_CH-1:0] det_q, det_d;
  logic [NUM_CH-1:0] pot_q, pot_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              tick;
  logic              clear_sig;
  logic [NUM_CH-1:0] def_hit;
  logic [NUM_CH-1:0] pot_hit;
  logic [4:0]        n_def;
  logic [16:0]       cnt_sum;

  assign tick = (state_q == StStrobe) && (per_q == 8'd0);

  // Control FSM: delay countdown, inject pulse, strobe period counter, exit conditions.
  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    per_d     = per_q;
    inject_o  = 1'b0;
    clear_sig = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          clear_sig = 1'b1;
          dly_d     = 8'(INJ_DELAY);
          if (INJ_DELAY == 0) state_d = StInject;
          else                state_d = StWaitInj;
        end
      end
      StWaitInj: begin
        if (stop_i) begin
          state_d = StDone;
        end else if (dly_q <= 8'd1) begin
          // The decrement that reaches zero hands over to the inject cycle.
          dly_d   = 8'd0;
          state_d = StInject;
        end else begin
          dly_d = dly_q - 8'd1;
        end
      end
      StInject: begin
        inject_o = 1'b1;
        per_d    = 8'd0;
        state_d  = stop_i ? StDone : StStrobe;
      end
      StStrobe: begin
        per_d = (per_q >= 8'(STROBE_PERIOD - 1)) ? 8'd0 : per_q + 8'd1;
        // Early drop looks at the registered flags, so DONE follows all_detected_o by one edge.
        if (stop_i || all_detected_o) state_d = StDone;
      end
      StDone: begin
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // Per-channel mismatch classification of the current inputs.
  always_comb begin
    def_hit = '0;
    pot_hit = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      def_hit[c] = |((obs.obs_data_i[c*DATA_W +: DATA_W] ^ obs.gold_data_i[c*DATA_W +: DATA_W])
                     & ~obs.obs_xmask_i[c*DATA_W +: DATA_W]);
      // !== also flags X on masked bits in simulation; synthesis sees a plain inequality.
      pot_hit[c] = (((obs.obs_data_i[c*DATA_W +: DATA_W] ^ obs.gold_data_i[c*DATA_W +: DATA_W])
                     & obs.obs_xmask_i[c*DATA_W +: DATA_W]) !== '0);
    end
  end

  // Sticky flag and saturating mismatch-count update on strobe ticks.
  always_comb begin
    det_d   = det_q;
    pot_d   = pot_q;
    n_def   = '0;
    cnt_sum = '0;
    cnt_d   = cnt_q;
    if (tick) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (obs.obs_valid_i[c]) begin
          if (def_hit[c]) begin
            det_d[c] = 1'b1;
            pot_d[c] = 1'b0;
            n_def    = n_def + 5'd1;
          end else if (pot_hit[c] && !det_q[c]) begin
            pot_d[c] = 1'b1;
          end
        end
      end
      cnt_sum = {1'b0, cnt_q} + {12'd0, n_def};
      cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end

  // State and result registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      dly_q   <= '0;
      per_q   <= '0;
      det_q   <= '0;
      pot_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      per_q   <= per_d;
      det_q   <= det_d;
      pot_q   <= pot_d;
      cnt_q   <= cnt_d;
    end
  end

  assign detect_o       = det_q;
  assign potential_o    = pot_q;
  assign mism_cnt_o     = cnt_q;
  assign all_detected_o = &det_q;
  assign done_o         = (state_q == StDone);

`ifdef FS_STROBE_MISR_EN
  // Fibonacci tap masks (shift-left form) for the supported widths 4, 8, 16, 24, 32.
  localparam logic [31:0] TapsFull = (DATA_W == 4)  ? 32'h0000_000C :
                                     (DATA_W == 8)  ? 32'h0000_00B8 :
                                     (DATA_W == 16) ? 32'h0000_D008 :
                                     (DATA_W == 24) ? 32'h00E1_0000 :
                                                      32'h8020_0003;
  localparam logic [DATA_W-1:0] Taps = TapsFull[DATA_W-1:0];

  logic [NUM_CH*DATA_W-1:0] sig_q, sig_d;

  // MISR next state: clear on test start, compact unmasked data on valid ticks.
  always_comb begin
    sig_d = sig_q;
    if (clear_sig) begin
      sig_d = '0;
    end else if (tick) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (obs.obs_valid_i[c]) begin
          sig_d[c*DATA_W +: DATA_W] =
              {sig_q[c*DATA_W +: DATA_W-1], ^(sig_q[c*DATA_W +: DATA_W] & Taps)}
              ^ (obs.obs_data_i[c*DATA_W +: DATA_W] & ~obs.obs_xmask_i[c*DATA_W +: DATA_W]);
        end
      end
    end
  end

  // MISR signature registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) sig_q <= '0;
    else       sig_q <= sig_d;
  end

  assign sig_o = sig_q;
`else
  assign sig_o = '0;
`endif

endmodule

// File: doc/fs_strobe_monitor.md
# fs_strobe_monitor

Parametrised, synthesizable successor to the fault-simulation strobe used around `fpu_gen_fp_wrapper_i`. It generalises that strobe from one observation point to `NUM_CH` channels of `DATA_W` bits and adds:
- a programmable injection delay;
- a strobe period;
- distinct definite (ON) and potential (PN) detection per channel;
- early drop once every channel is detected.

It sits in the test wrapper beside the DUT and compares DUT outputs against golden values.

## Interface
- `NUM_CH`, default 4: number of observation channels (1..16).
- `DATA_W`, default 32: bits per channel.
- `INJ_DELAY`, default 8: cycles from `start_i` to the inject pulse (0..255).
- `STROBE_PERIOD`, default 1: compare every Nth cycle in `STROBE` state (1..255).

Ports:
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `start_i`  in  1  begin test; sampled only in `IDLE`.
- `stop_i`  in  1  end of test; sampled in `WAIT_INJ`, `INJECT`, `STROBE`.
- `obs_valid_i`  in  `NUM_CH`  per-channel observation valid.
- `obs_data_i`  in  `NUM_CH*DATA_W`  DUT values, channel c at `[c*DATA_W +: DATA_W]`.
- `gold_data_i`  in  `NUM_CH*DATA_W`  expected values, same packing.
- `obs_xmask_i`  in  `NUM_CH*DATA_W`  1 = bit unknown/uncertain.
- `inject_o`  out  1  one-cycle fault-injection pulse.
- `detect_o`  out  `NUM_CH`  sticky definite mismatch (ON).
- `potential_o`  out  `NUM_CH`  sticky potential mismatch (PN).
- `all_detected_o`  out  1  every channel has `detect_o` set.
- `done_o`  out  1  high in `DONE`.
- `mism_cnt_o`  out  16  saturating count of channel-strobes with a definite mismatch.
- `sig_o`  out  `NUM_CH*DATA_W`  per-channel MISR signature.

## Operation
State machine: `IDLE`, `WAIT_INJ`, `INJECT`, `STROBE`, `DONE`.
- `IDLE` -> `WAIT_INJ` on `start_i`. Load the delay counter with `INJ_DELAY`. If `INJ_DELAY`==0, go directly to `INJECT`.
- `WAIT_INJ`: decrement each cycle; reaching 0 -> `INJECT`.
- `INJECT`: `inject_o`=1 for exactly this cycle -> `STROBE`. Clear the period counter.
- `STROBE`: the period counter counts 0..`STROBE_PERIOD`-1 and wraps. A strobe tick occurs when the counter is 0, i.e. on the first `STROBE` cycle and every `STROBE_PERIOD` cycles after.
- `DONE`: terminal. Leave it only by `rst_i`. `start_i` is ignored here.

Per-channel compare on a strobe tick with `obs_valid_i[c]`=1:
- `d = (obs ^ gold) & ~xmask`. If `d` != 0, set `detect_o[c]` and clear `potential_o[c]`.
- Otherwise, if `((obs ^ gold) & xmask)` != 0, or `xmask` bits are set where `obs`/`gold` contain X in simulation, set `potential_o[c]`, but only if `detect_o[c]`=0.
- `detect_o` and `potential_o` are never both 1.
- Invalid channels are not compared.

Other behaviour:
- `mism_cnt_o` adds the number of channels with `d` != 0 on each tick (popcount), saturating at 16'hFFFF.
- Exit to `DONE` when `stop_i`=1, or when `all_detected_o` becomes 1 (early drop).
- If `stop_i` and a strobe tick coincide, the tick's compare is still recorded.
- Reset values: state `IDLE`, all outputs 0, counters 0, `sig_o` 0.
- `rst_i` mid-test aborts from any state next edge and clears sticky flags.

## Timing
- Compare results are registered. `detect_o`, `potential_o` and `mism_cnt_o` update on the edge that ends the tick cycle (1-cycle latency).
- `all_detected_o` is combinational from the `detect_o` registers.
- The `DONE` transition on early drop occurs on the edge after `all_detected_o` rises.
- `inject_o` rises exactly `INJ_DELAY`+1 edges after the edge sampling `start_i`.
- No handshake back-pressure. Inputs are sampled only on ticks.

## Configuration
- `FS_STROBE_MISR_EN` defined: each channel has a `DATA_W`-bit MISR, using the primitive polynomial for `DATA_W` from the team's LFSR package.
  - Update: `sig = {sig[DATA_W-2:0], fb} ^ (obs & ~xmask)` on every tick with `obs_valid_i[c]`=1.
  - The MISR holds otherwise and clears on reset and on `IDLE`->`WAIT_INJ`.
- Not defined: no MISR logic; `sig_o` tied to 0.

## Test plan
- Parameters `NUM_CH`=4, `INJ_DELAY`=3. Pulse `start_i` at cycle 10 -> `inject_o` high only at cycle 14.
- With `STROBE_PERIOD`=4 and `obs`==`gold` throughout -> ticks at `STROBE` cycles 0,4,8,... Flags stay 0, `mism_cnt_o`=0, and `stop_i` at cycle 30 gives `done_o`=1.
- Channel 2 `obs`=32'h0000_0001 vs `gold`=0, `xmask`=0 -> `detect_o`=4'b0100 one cycle after the tick. Channel 1 differing only on a masked bit -> `potential_o`=4'b0010.
- All four channels mismatch on one tick -> `mism_cnt_o`=4, `all_detected_o`=1, `done_o`=1 next cycle. A later `start_i` is ignored.
- `rst_i` asserted in `STROBE` with `detect_o`=4'b0001 -> next cycle all outputs 0, state `IDLE`, and a new `start_i` restarts the delay.
- With `FS_STROBE_MISR_EN`, `DATA_W`=8, and channel 0 fed 8'h01, 8'h02, 8'h04 -> `sig_o[7:0]` matches the reference model. Without the macro -> `sig_o`=0.
